// File: rtl/spi_sample_scheduler_if.sv
// SPI engine handshake shared by the sample scheduler (master) and the shift engine (slave).
interface spi_sample_scheduler_if #(
   parameter int FRAME_W = 16
);
   logic               spi_start;
   logic [FRAME_W-1:0] spi_tx;
   logic               spi_busy;
   logic               spi_done;
   logic [FRAME_W-1:0] spi_rx;

   modport master (
      output spi_start, spi_tx,
      input  spi_busy, spi_done, spi_rx
   );

   modport slave (
      input  spi_start, spi_tx,
      output spi_busy, spi_done, spi_rx
   );
endinterface

// File: rtl/spi_sample_scheduler.sv
// Periodic sensor-sample scheduler sharing one SPI engine with host configuration transfers.
// Optional macro OVERRUN_COUNT_EN adds a saturating 8-bit overrun counter output.
module spi_sample_scheduler #(
   parameter int                 SAMPLE_PERIOD = 405,
   parameter int                 FRAME_W       = 16,
   parameter logic [FRAME_W-1:0] SAMPLE_CMD    = 16'h8000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_enable,
   input  logic                  i_cfg_req,
   input  logic [FRAME_W-1:0]    i_cfg_word,
   output logic                  o_cfg_ack,
   output logic [FRAME_W-1:0]    o_cfg_rdata,
   output logic                  o_sample_valid,
   output logic [FRAME_W-1:0]    o_sample_data,
   output logic                  o_sample_clk_out,
   output logic                  o_overrun,
`ifdef OVERRUN_COUNT_EN
   output logic [7:0]            o_overrun_cnt,
`endif
   spi_sample_scheduler_if.master spi
);

   localparam int                 TIMER_W = $clog2(SAMPLE_PERIOD);
   localparam logic [TIMER_W-1:0] LAST    = TIMER_W'(SAMPLE_PERIOD - 1);
   localparam logic [TIMER_W-1:0] HALF    = TIMER_W'(SAMPLE_PERIOD / 2);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic {GRANT_CFG, GRANT_SAMPLE} grant_t;

   state_t               r_state;
   grant_t               r_lastGrant;
   logic [TIMER_W-1:0]   r_timer;
   logic                 r_samplePending;
   logic                 r_overrun;
   logic                 r_sampleClk;
   logic                 r_spiStart;
   logic [FRAME_W-1:0]   r_spiTx;
   logic                 r_cfgAck;
   logic [FRAME_W-1:0]   r_cfgRdata;
   logic                 r_sampleValid;
   logic [FRAME_W-1:0]   r_sampleData;

   logic [TIMER_W-1:0]   w_timerNext;
   logic                 w_tick;
   logic                 w_sampleConsumed;
   logic                 w_grantCfg;

   assign w_tick           = i_enable && (r_timer == LAST);
   assign w_sampleConsumed = (r_state == DONE) && (r_lastGrant == GRANT_SAMPLE);

   always_comb begin
      w_timerNext = '0;
      if (i_enable && (r_timer != LAST))
         w_timerNext = r_timer + 1'b1;
   end

   // On a conflict the requester not served last time wins, so neither side starves.
   always_comb begin
      w_grantCfg = i_cfg_req;
      if (i_cfg_req && r_samplePending)
         w_grantCfg = (r_lastGrant == GRANT_SAMPLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer     <= '0;
         r_sampleClk <= 1'b0;
      end else begin
         r_timer     <= w_timerNext;
         r_sampleClk <= i_enable && (w_timerNext < HALF);
      end
   end

   // A tick landing on the DONE cycle of a sample re-arms the request instead of counting as lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_samplePending <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         r_overrun <= w_tick && r_samplePending && !w_sampleConsumed;
         if (!i_enable)
            r_samplePending <= 1'b0;
         else if (w_tick)
            r_samplePending <= 1'b1;
         else if (w_sampleConsumed)
            r_samplePending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_lastGrant   <= GRANT_SAMPLE;
         r_spiStart    <= 1'b0;
         r_spiTx       <= '0;
         r_cfgAck      <= 1'b0;
         r_cfgRdata    <= '0;
         r_sampleValid <= 1'b0;
         r_sampleData  <= '0;
      end else begin
         r_cfgAck      <= 1'b0;
         r_sampleValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_cfg_req || r_samplePending) begin
                  r_lastGrant <= w_grantCfg ? GRANT_CFG : GRANT_SAMPLE;
                  r_spiTx     <= w_grantCfg ? i_cfg_word : SAMPLE_CMD;
                  r_spiStart  <= 1'b1;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (spi.spi_busy) begin
                  r_spiStart <= 1'b0;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               if (spi.spi_done) begin
                  if (r_lastGrant == GRANT_CFG) begin
                     r_cfgAck   <= 1'b1;
                     r_cfgRdata <= spi.spi_rx;
                  end else begin
                     r_sampleValid <= 1'b1;
                     r_sampleData  <= spi.spi_rx;
                  end
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef OVERRUN_COUNT_EN
   logic [7:0] r_overrunCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_overrunCnt <= 8'd0;
      else if (r_overrun && (r_overrunCnt != 8'hFF))
         r_overrunCnt <= r_overrunCnt + 8'd1;
   end

   assign o_overrun_cnt = r_overrunCnt;
`endif

   assign spi.spi_start      = r_spiStart;
   assign spi.spi_tx         = r_spiTx;
   assign o_cfg_ack          = r_cfgAck;
   assign o_cfg_rdata        = r_cfgRdata;
   assign o_sample_valid     = r_sampleValid;
   assign o_sample_data      = r_sampleData;
   assign o_sample_clk_out   = r_sampleClk;
   assign o_overrun          = r_overrun;

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Directed bench for spi_sample_scheduler with SAMPLE_PERIOD=8 and a small behavioural SPI engine.
module tb_spi_sample_scheduler;

   localparam int          PERIOD      = 8;
   localparam logic [15:0] CMD         = 16'h8000;
   localparam logic [15:0] CFG_WORD    = 16'hA5C3;
   localparam logic [15:0] SAMPLE_RESP = 16'h1234;
   localparam logic [15:0] CFG_RESP    = 16'h5A3C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        cfgReq = 1'b0;
   logic [15:0] cfgWord = CFG_WORD;
   logic        cfgAck, sampleValid, sampleClk, overrun;
   logic [15:0] cfgRdata, sampleData;
`ifdef OVERRUN_COUNT_EN
   logic [7:0]  overrunCnt;
`endif

   spi_sample_scheduler_if #(.FRAME_W(16)) spiIf ();

   spi_sample_scheduler #(
      .SAMPLE_PERIOD (PERIOD),
      .FRAME_W       (16),
      .SAMPLE_CMD    (CMD)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_enable         (enable),
      .i_cfg_req        (cfgReq),
      .i_cfg_word       (cfgWord),
      .o_cfg_ack        (cfgAck),
      .o_cfg_rdata      (cfgRdata),
      .o_sample_valid   (sampleValid),
      .o_sample_data    (sampleData),
      .o_sample_clk_out (sampleClk),
      .o_overrun        (overrun),
`ifdef OVERRUN_COUNT_EN
      .o_overrun_cnt    (overrunCnt),
`endif
      .spi              (spiIf)
   );

   always #5 clk = ~clk;

   // SPI engine model: accepts a start, stays busy, then pulses done modelDelay clocks after accepting.
   int          modelDelay = 19;
   int          modelCnt;
   logic        stall = 1'b0;
   logic [15:0] txCap;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spiIf.spi_busy <= 1'b0;
         spiIf.spi_done <= 1'b0;
         spiIf.spi_rx   <= '0;
         modelCnt       <= 0;
         txCap          <= '0;
      end else begin
         spiIf.spi_done <= 1'b0;
         if (stall) begin
            spiIf.spi_busy <= 1'b1;
         end else if (!spiIf.spi_busy && spiIf.spi_start && !spiIf.spi_done) begin
            spiIf.spi_busy <= 1'b1;
            modelCnt       <= modelDelay;
            txCap          <= spiIf.spi_tx;
         end else if (spiIf.spi_busy) begin
            if (modelCnt <= 1) begin
               spiIf.spi_busy <= 1'b0;
               spiIf.spi_done <= 1'b1;
               spiIf.spi_rx   <= (txCap == CMD) ? SAMPLE_RESP : ~txCap;
            end else begin
               modelCnt <= modelCnt - 1;
            end
         end
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          stepNo, startCount, validCount, ackCount, ovCount, clkHighCount;
   int          firstStartStep, validStep, ackStep;
   int          cfgMode;
   logic        prevStart;
   logic [15:0] txLog [8];
   logic        clkLog [64];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic req);
      enable = en;
      cfgReq = req;
   endtask

   task automatic clearMonitor();
      stepNo = 0; startCount = 0; validCount = 0; ackCount = 0; ovCount = 0; clkHighCount = 0;
      firstStartStep = -1; validStep = -1; ackStep = -1; prevStart = 1'b0;
      for (int i = 0; i < 8; i++) txLog[i] = '0;
      for (int i = 0; i < 64; i++) clkLog[i] = 1'b0;
   endtask

   // One clock: sample outputs 1 ns after the edge and update the event log.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      stepNo++;
      if (spiIf.spi_start && !prevStart) begin
         if (startCount < 8) txLog[startCount[2:0]] = spiIf.spi_tx;
         if (startCount == 0) firstStartStep = stepNo;
         startCount++;
      end
      prevStart = spiIf.spi_start;
      if (sampleValid) begin
         validCount++;
         validStep = stepNo;
      end
      if (cfgAck) begin
         ackCount++;
         ackStep = stepNo;
         if (cfgMode == 1) cfgReq = 1'b0;
      end
      if (overrun) ovCount++;
      if (sampleClk) clkHighCount++;
      if (stepNo < 64) clkLog[stepNo] = sampleClk;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clearMonitor();
   endtask

   initial begin
      cfgMode = 0;
      clearMonitor();
      applyStimulus(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ctrl", {spiIf.spi_start, cfgAck, sampleValid, overrun, sampleClk}, 0);
      checkOutput("reset_spi_tx", spiIf.spi_tx, 0);
      checkOutput("reset_sample_data", sampleData, 0);
      checkOutput("reset_cfg_rdata", cfgRdata, 0);

      rst_n = 1'b1;
      clearMonitor();
      repeat (31) stepCycle();
      checkOutput("first_start_step", firstStartStep, 9);
      checkOutput("first_tx", txLog[0], CMD);
      checkOutput("clk_out_t3", clkLog[3], 1);
      checkOutput("clk_out_t4", clkLog[4], 0);
      checkOutput("clk_out_t0", clkLog[8], 1);
      checkOutput("sample_valid_count", validCount, 1);
      checkOutput("sample_valid_step", validStep, 30);
      checkOutput("sample_data", sampleData, SAMPLE_RESP);
      checkOutput("overrun_count", ovCount, 2);

      applyStimulus(1'b0, 1'b0);
      clearMonitor();
      repeat (50) stepCycle();
      checkOutput("disabled_starts", startCount, 0);
      checkOutput("disabled_clk_high", clkHighCount, 0);

      applyStimulus(1'b1, 1'b0);
      clearMonitor();
      repeat (12) stepCycle();
      checkOutput("reenable_start_step", firstStartStep, 9);
      checkOutput("reenable_tx", txLog[0], CMD);

      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_ctrl", {spiIf.spi_start, cfgAck, sampleValid, overrun, sampleClk}, 0);
      checkOutput("async_rst_spi_tx", spiIf.spi_tx, 0);
      checkOutput("async_rst_sample_data", sampleData, 0);
      repeat (2) @(posedge clk);
      applyStimulus(1'b0, 1'b0);
      #1 rst_n = 1'b1;
      clearMonitor();
      repeat (40) stepCycle();
      checkOutput("post_rst_valid", validCount, 0);
      checkOutput("post_rst_ack", ackCount, 0);
      checkOutput("post_rst_starts", startCount, 0);

      modelDelay = 3;
      cfgMode = 1;
      applyStimulus(1'b1, 1'b0);
      doReset();
      repeat (7) stepCycle();
      applyStimulus(1'b1, 1'b1);
      repeat (18) stepCycle();
      checkOutput("tick_cfg_grant", txLog[0], CFG_WORD);
      checkOutput("tick_next_grant", txLog[1], CMD);
      checkOutput("cfg_ack_count", ackCount, 1);
      checkOutput("cfg_ack_step", ackStep, 13);
      checkOutput("cfg_rdata", cfgRdata, CFG_RESP);
      checkOutput("cfg_then_sample_step", validStep, 20);
      checkOutput("cfg_then_sample_data", sampleData, SAMPLE_RESP);

      modelDelay = 10;
      cfgMode = 2;
      applyStimulus(1'b1, 1'b0);
      doReset();
      repeat (8) stepCycle();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 150 && startCount < 4; i++) stepCycle();
      checkOutput("alt_grant_count", (startCount >= 4), 1);
      checkOutput("alt_grant0", txLog[0], CFG_WORD);
      checkOutput("alt_grant1", txLog[1], CMD);
      checkOutput("alt_grant2", txLog[2], CFG_WORD);
      checkOutput("alt_grant3", txLog[3], CMD);
      checkOutput("alt_cfg_rdata", cfgRdata, CFG_RESP);

      cfgMode = 0;
      stall = 1'b1;
      applyStimulus(1'b1, 1'b0);
      doReset();
      repeat (300 * PERIOD + 4) stepCycle();
      checkOutput("stall_starts", startCount, 1);
      checkOutput("stall_overruns", ovCount, 299);
`ifdef OVERRUN_COUNT_EN
      checkOutput("overrun_cnt_sat", overrunCnt, 255);
`endif
      stall = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
